// File: rtl/vred_and_or_xor_pipe.sv
// rtl/vred_and_or_xor_pipe.sv - pipelined multi-beat vector and/or/xor reduction
// Identity-substituted lanes feed a registered pairwise tree; the tree output folds into a scalar-seeded accumulator.
module vred_and_or_xor_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 4,
  parameter int OPSEL_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] in_vec,
  input  logic [LANES-1:0]            in_mask,
  input  logic [DATA_WIDTH-1:0]       in_scalar,
  input  logic [OPSEL_WIDTH-1:0]      in_opSel,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       out_vec
);

  localparam int LOG = $clog2(LANES);
  localparam logic [OPSEL_WIDTH-1:0] OP_AND = OPSEL_WIDTH'(1);
  localparam logic [OPSEL_WIDTH-1:0] OP_OR  = OPSEL_WIDTH'(2);
  localparam logic [OPSEL_WIDTH-1:0] OP_XOR = OPSEL_WIDTH'(3);
  localparam logic [DATA_WIDTH-1:0]  ONES   = {DATA_WIDTH{1'b1}};
  localparam logic [DATA_WIDTH-1:0]  ZEROS  = {DATA_WIDTH{1'b0}};

  // Opcode 00 yields zero, which also forces the accumulator to zero.
  function automatic logic [DATA_WIDTH-1:0] red_op(
    input logic [OPSEL_WIDTH-1:0] op,
    input logic [DATA_WIDTH-1:0]  a,
    input logic [DATA_WIDTH-1:0]  b
  );
    case (op)
      OP_AND:  red_op = a & b;
      OP_OR:   red_op = a | b;
      OP_XOR:  red_op = a ^ b;
      default: red_op = ZEROS;
    endcase
  endfunction

  logic [LANES-1:0][DATA_WIDTH-1:0] lanes_sub;
  logic [LANES-1:0][DATA_WIDTH-1:0] tree_q [LOG+1];
  logic [OPSEL_WIDTH-1:0]           op_q     [LOG+1];
  logic [DATA_WIDTH-1:0]            scalar_q [LOG+1];
  logic [LOG:0]                     valid_q;
  logic [LOG:0]                     first_q;
  logic [LOG:0]                     last_q;
  logic [DATA_WIDTH-1:0]            acc_q;
  logic [DATA_WIDTH-1:0]            acc_next;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lanes_sub[i] = in_mask[i] ? in_vec[i*DATA_WIDTH +: DATA_WIDTH]
                                : ((in_opSel == OP_AND) ? ONES : ZEROS);
    end
  end

  // Datapath and sideband carry no reset; only the valid chain qualifies them.
  always_ff @(posedge clk) begin
    tree_q[0]   <= lanes_sub;
    op_q[0]     <= in_opSel;
    scalar_q[0] <= in_scalar;
    first_q     <= {first_q[LOG-1:0], in_first};
    last_q      <= {last_q[LOG-1:0], in_last};
    for (int s = 1; s <= LOG; s++) begin
      for (int i = 0; i < LANES / 2; i++) begin
        tree_q[s][i] <= red_op(op_q[s-1], tree_q[s-1][2*i], tree_q[s-1][2*i+1]);
      end
      op_q[s]     <= op_q[s-1];
      scalar_q[s] <= scalar_q[s-1];
    end
  end

  assign acc_next = red_op(op_q[LOG], first_q[LOG] ? scalar_q[LOG] : acc_q, tree_q[LOG][0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      acc_q     <= ZEROS;
      out_valid <= 1'b0;
      out_vec   <= ZEROS;
    end else begin
      valid_q   <= {valid_q[LOG-1:0], in_valid};
      out_valid <= 1'b0;
      if (valid_q[LOG]) begin
        acc_q <= acc_next;
        if (last_q[LOG]) begin
          out_valid <= 1'b1;
          out_vec   <= acc_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_vred_and_or_xor_pipe.sv
// tb/tb_vred_and_or_xor_pipe.sv - directed and random bench for vred_and_or_xor_pipe
// A per-reduction fold model feeds a fixed-latency expectation queue checked every cycle.
module tb_vred_and_or_xor_pipe;

  localparam int DW  = 32;
  localparam int LN  = 4;
  localparam int LAT = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_first, in_last;
  logic [LN*DW-1:0] in_vec;
  logic [LN-1:0]   in_mask;
  logic [DW-1:0]   in_scalar;
  logic [1:0]      in_opSel;
  logic            out_valid;
  logic [DW-1:0]   out_vec;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          dl[$];
  logic [DW-1:0] m_acc;
  logic [DW-1:0] exp_vec;
  logic          exp_v;

  vred_and_or_xor_pipe #(.DATA_WIDTH(DW), .LANES(LN), .OPSEL_WIDTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_vec    (in_vec),
    .in_mask   (in_mask),
    .in_scalar (in_scalar),
    .in_opSel  (in_opSel),
    .out_valid (out_valid),
    .out_vec   (out_vec)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] op_f(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    case (op)
      2'b01:   return a & b;
      2'b10:   return a | b;
      2'b11:   return a ^ b;
      default: return '0;
    endcase
  endfunction

  // Fold of the active lanes, starting from the operation's identity.
  function automatic logic [DW-1:0] lanes_f(input logic [1:0] op, input logic [LN*DW-1:0] vec, input logic [LN-1:0] mask);
    logic [DW-1:0] r;
    r = (op == 2'b01) ? {DW{1'b1}} : '0;
    for (int i = 0; i < LN; i++)
      if (mask[i]) r = op_f(op, r, vec[i*DW +: DW]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic model_reset();
    dl = {};
    repeat (LAT) dl.push_back('0);
    m_acc   = '0;
    exp_vec = '0;
    exp_v   = 1'b0;
  endtask

  task automatic step(input logic v, input logic f, input logic l, input logic [LN*DW-1:0] vec,
                      input logic [LN-1:0] m, input logic [DW-1:0] sc, input logic [1:0] op, input logic r);
    ent_t ne, oe;
    rst = r; in_valid = v; in_first = f; in_last = l;
    in_vec = vec; in_mask = m; in_scalar = sc; in_opSel = op;
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      ne = '0;
      if (v) begin
        m_acc = op_f(op, f ? sc : m_acc, lanes_f(op, vec, m));
        if (l) ne = '{v: 1'b1, d: m_acc};
      end
      dl.push_back(ne);
      oe = dl.pop_front();
      exp_v = oe.v;
      if (oe.v) exp_vec = oe.d;
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    check("out_vec", out_vec, exp_vec);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b1, '1, '1, '1, 2'b11, 1'b0);
  endtask

  task automatic one(input logic f, input logic l, input logic [LN*DW-1:0] vec,
                     input logic [LN-1:0] m, input logic [DW-1:0] sc, input logic [1:0] op);
    step(1'b1, f, l, vec, m, sc, op, 1'b0);
  endtask

  initial begin
    logic [1:0] op;
    int nb;
    bit abandon;
    logic [LN*DW-1:0] rv;
    model_reset();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    check("reset_out_vec", out_vec, 32'h0);

    one(1'b1, 1'b1, {32'hFFFFFF0F, 32'hFFFFFFFF, 32'hF0FFFFFF, 32'hFFFF00FF}, 4'b1111, 32'hFFFFFFFF, 2'b01);
    idle(2);
    check("and_not_yet", {31'b0, out_valid}, 32'h0);
    idle(1);
    check("and_latency", {31'b0, out_valid}, 32'h1);
    check("and_result", out_vec, 32'hF0FF000F);

    one(1'b1, 1'b1, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b0101, 32'h10, 2'b11);
    idle(LAT);
    check("xor_masked", out_vec, 32'h15);
    one(1'b1, 1'b1, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b0000, 32'h1234, 2'b01);
    idle(LAT);
    check("and_all_masked", out_vec, 32'h1234);
    one(1'b1, 1'b1, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111, 32'h1234, 2'b00);
    idle(LAT);
    check("op_none", out_vec, 32'h0);

    one(1'b1, 1'b0, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111, 32'h0, 2'b10);
    idle(1);
    one(1'b0, 1'b0, {32'h80, 32'h40, 32'h20, 32'h10}, 4'b1111, 32'hDEAD, 2'b10);
    idle(1);
    one(1'b0, 1'b1, {32'h800, 32'h400, 32'h200, 32'h100}, 4'b1111, 32'hBEEF, 2'b10);
    idle(LAT);
    check("or_multibeat", out_vec, 32'hFFF);

    one(1'b1, 1'b1, {32'h0, 32'h0, 32'h05, 32'hA0}, 4'b1111, 32'h0, 2'b11);
    one(1'b1, 1'b1, {32'hFF, 32'hFF, 32'h0F, 32'hFF}, 4'b1111, 32'hFF, 2'b01);
    idle(2);
    check("b2b_first", out_vec, 32'hA5);
    idle(1);
    check("b2b_second_valid", {31'b0, out_valid}, 32'h1);
    check("b2b_second", out_vec, 32'h0F);
    idle(2);
    check("b2b_hold", out_vec, 32'h0F);

    one(1'b1, 1'b0, {32'h1000, 32'h1000, 32'h1000, 32'h1000}, 4'b1111, 32'h7, 2'b10);
    one(1'b0, 1'b0, {32'h2000, 32'h0, 32'h0, 32'h0}, 4'b1111, 32'h0, 2'b10);
    one(1'b1, 1'b1, {32'h0, 32'h0, 32'h30, 32'h0}, 4'b1111, 32'h3, 2'b10);
    idle(LAT + 1);
    check("restart", out_vec, 32'h33);

    one(1'b1, 1'b0, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111, 32'h0, 2'b10);
    one(1'b0, 1'b0, {32'h80, 32'h40, 32'h20, 32'h10}, 4'b1111, 32'h0, 2'b10);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 2'b00, 1'b1);
    idle(LAT + 1);
    check("reset_mid_valid", {31'b0, out_valid}, 32'h0);
    check("reset_mid_vec", out_vec, 32'h0);
    one(1'b1, 1'b1, {32'h8, 32'h4, 32'h2, 32'h1}, 4'b1111, 32'h0, 2'b10);
    idle(LAT);
    check("after_reset_or", out_vec, 32'hF);

    for (int r = 0; r < 80; r++) begin
      op      = (r % 9 == 8) ? 2'b00 : 2'($urandom_range(1, 3));
      nb      = $urandom_range(1, 4);
      abandon = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < nb; b++) begin
        rv = {$urandom, $urandom, $urandom, $urandom};
        if (op == 2'b01) rv = rv | {$urandom, $urandom, $urandom, $urandom};
        one(b == 0, (b == nb - 1) && !abandon, rv, 4'($urandom), $urandom, op);
        if ($urandom_range(0, 3) == 0)
          step(1'b0, 1'($urandom), 1'($urandom), {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), $urandom, op, 1'b0);
      end
    end
    idle(LAT + 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vred_and_or_xor_pipe.md
# vred_and_or_xor_pipe

Pipelined, multi-beat vector logical reduction unit (vredand/vredor/vredxor) for the vALU. Each beat carries LANES elements and an element mask. Elements are reduced through a registered log2(LANES)-deep tree, then folded into an accumulator seeded from the scalar operand (vs1[0]). One result is produced per reduction. The unit sits beside the other vALU reduction units and accepts one beat per cycle with no backpressure.

## Interface
- DATA_WIDTH, 32, element width in bits
- LANES, 4, elements per beat; power of two, >= 2
- OPSEL_WIDTH, 2, opcode width

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  beat present this cycle
- in_first  in  1  first beat of a reduction (qualified by in_valid)
- in_last  in  1  last beat of a reduction (qualified by in_valid); may coincide with in_first
- in_vec  in  LANES*DATA_WIDTH  elements; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_mask  in  LANES  1 = element active
- in_scalar  in  DATA_WIDTH  initial value; sampled only on an in_first beat
- in_opSel  in  OPSEL_WIDTH  01 = and, 10 = or, 11 = xor, 00 = none
- out_valid  out  1  one-cycle pulse, result available
- out_vec  out  DATA_WIDTH  reduction result; holds its value until the next out_valid

## Operation
- Identity substitution at input: a masked-off lane takes the identity value for its operation.
  - and: all-ones.
  - or / xor: zero.
  - 00: zero.
- Tree: log2(LANES) registered stages. Each stage combines adjacent pairs with in_opSel.
- Sideband carried with every beat through all stages: valid, first, last, opSel, scalar.
- Accumulator stage, for a valid beat leaving the tree:
  - first beat: acc <= op(scalar, tree_result)
  - other beats: acc <= op(acc, tree_result)
  - bubble (valid = 0): acc holds.
- opSel 00 forces the tree result and acc to 0 (legacy "none" behaviour).
- opSel must be constant from the in_first beat to the in_last beat. Each beat uses its own opSel; mixed opcodes within one reduction are undefined.
- Bubbles (in_valid = 0) are permitted between beats of a reduction; the result is unaffected.
- in_first while a reduction is open: the open reduction is abandoned and acc reseeds; the abandoned reduction produces no out_valid.
- Valid beat without in_first and with no reduction ever started: folds onto acc's current value (0 after reset).
- All lanes masked: the result equals the scalar (for and/or/xor).
- A new reduction may begin on the cycle after an in_last beat. Every reduction produces exactly one out_valid.

## Timing
- Reset values: out_valid = 0, out_vec = 0, acc = 0, all pipeline valid bits = 0.
- Reset mid-operation clears all in-flight beats; no out_valid is produced for them.
- Latency L = log2(LANES) + 1 cycles. A last beat sampled at edge t gives out_valid = 1 and out_vec valid after edge t+L (L = 3 for LANES = 4).
- Throughput is one beat per cycle. Single-beat reductions issued on consecutive cycles give out_valid on consecutive cycles.
- out_vec updates only on cycles where out_valid is asserted.

## Test plan
- Single-beat and, LANES=4, DW=32: lanes {FFFF00FF, F0FFFFFF, FFFFFFFF, FFFFFF0F}, mask 1111, scalar FFFFFFFF, first = last = 1 -> out_valid exactly 3 cycles later, out_vec = F0FF000F.
- Masked xor: lanes {1, 2, 4, 8}, mask 0101, scalar 0x10 -> out_vec = 0x15. Then all-masked and with scalar 0x1234 -> 0x1234. Then opSel 00 -> 0.
- Multi-beat or with bubbles: 3 beats with lane values 0x1/0x2/0x4/0x8, then 0x10..0x80, then 0x100..0x800, with one idle cycle between beats, scalar 0 -> a single out_valid 3 cycles after the last beat, out_vec = 0xFFF.
- Back-to-back: single-beat xor reduction A (result 0xA5) followed next cycle by single-beat and reduction B (result 0x0F) -> out_valid on two consecutive cycles, 0xA5 then 0x0F; out_vec holds 0x0F afterwards.
- Restart: in_first issued mid-reduction -> only the new reduction's result appears; the abandoned one produces no pulse.
- Reset mid-operation: rst asserted after 2 of 3 beats -> out_valid stays 0 and out_vec = 0. A following single-beat or of {1, 2, 4, 8}, scalar 0 -> 0xF.
